// File: rtl/cvita_gen_pkg.sv
// Shared CHDR definitions for the CVITA ramp packet source: header field layout,
// packet-type encodings, generator state encoding and a header builder.
package cvita_gen_pkg;

    localparam int HDR_TYPE_LSB = 62;
    localparam int HDR_TIME_BIT = 61;
    localparam int HDR_EOB_BIT  = 60;
    localparam int HDR_SEQ_LSB  = 48;
    localparam int SEQ_W        = 12;
    localparam int HDR_LEN_LSB  = 32;
    localparam int LENB_W       = 16;
    localparam int SID_W        = 32;

    typedef enum logic [1:0] {
        PKT_DATA = 2'b00,
        PKT_FC   = 2'b01,
        PKT_CMD  = 2'b10,
        PKT_RESP = 2'b11
    } pkt_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_TIME,
        ST_PAYLOAD,
        ST_GAP
    } state_e;

    // Packet length in bytes: header + optional timestamp + payload, truncated to 16 bits.
    function automatic logic [LENB_W-1:0] len_bytes(input logic [31:0] payload_words,
                                                    input logic        has_time);
        logic [31:0] total;
        total = (payload_words + 32'(has_time) + 32'd1) << 3;
        return total[LENB_W-1:0];
    endfunction

    function automatic logic [63:0] build_hdr(input pkt_type_e         pkt_type,
                                              input logic              has_time,
                                              input logic              eob,
                                              input logic [SEQ_W-1:0]  seqno,
                                              input logic [LENB_W-1:0] len_b,
                                              input logic [SID_W-1:0]  sid);
        logic [63:0] hdr;
        hdr                           = '0;
        hdr[HDR_TYPE_LSB +: 2]        = pkt_type;
        hdr[HDR_TIME_BIT]             = has_time;
        hdr[HDR_EOB_BIT]              = eob;
        hdr[HDR_SEQ_LSB +: SEQ_W]     = seqno;
        hdr[HDR_LEN_LSB +: LENB_W]    = len_b;
        hdr[0 +: SID_W]               = sid;
        return hdr;
    endfunction

endpackage

// File: rtl/cvita_ramp_pkt_gen.sv
// CVITA/CHDR packet source: header, optional timestamp, then a ramp payload
// (start + n*incr) on a 64-bit AXI-Stream, repeated for a counted or open-ended run.
module cvita_ramp_pkt_gen
    import cvita_gen_pkg::*;
#(
    parameter int LEN_W = 13,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_pkts,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [63:0]      ramp_start,
    input  logic [63:0]      ramp_incr,
    input  logic [15:0]      gap_cycles,
    input  logic [31:0]      sid,
    input  logic             has_time,
    input  logic [63:0]      timestamp,
    output logic [63:0]      o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkt_cnt
);

    state_e             state_q;
    logic [63:0]        o_tdata_q;
    logic               o_tlast_q;
    logic               o_tvalid_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   pkt_cnt_q;
    logic [SEQ_W-1:0]   seqno_q;
    logic               stop_seen_q;

    // Run controls captured on the accepted start
    logic [CNT_W-1:0]   num_pkts_q;
    logic [LEN_W-1:0]   len_q;
    logic [LENB_W-1:0]  lenb_q;
    logic [63:0]        ramp_start_q;
    logic [63:0]        ramp_incr_q;
    logic [15:0]        gap_q;
    logic [31:0]        sid_q;
    logic               has_time_q;
    logic [63:0]        ts_q;

    logic [63:0]        acc_q;
    logic [LEN_W-1:0]   word_cnt_q;
    logic [15:0]        gap_cnt_q;

    logic               xfer;
    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   word_d;
    logic [CNT_W-1:0]   pkt_cnt_d;
    logic [SEQ_W-1:0]   seqno_d;
    logic [63:0]        ts_d;
    logic               stop_any;
    logic               end_after_tlast;
    logic               end_after_gap;
    logic [63:0]        hdr_after_tlast;
    logic [63:0]        hdr_after_gap;

    assign xfer      = o_tvalid_q & o_tready;
    assign len_eff   = (payload_len == '0) ? LEN_W'(1) : payload_len;
    assign word_d    = word_cnt_q + LEN_W'(1);
    assign pkt_cnt_d = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + CNT_W'(1);
    assign seqno_d   = seqno_q + SEQ_W'(1);
    assign ts_d      = ts_q + 64'(len_q);
    assign stop_any  = stop_seen_q | stop;

    assign end_after_tlast = ((num_pkts_q != '0) && (pkt_cnt_d == num_pkts_q)) || stop_any;
    assign end_after_gap   = ((num_pkts_q != '0) && (pkt_cnt_q == num_pkts_q)) || stop_any;

    // eob marks the packet that will complete a finite run
    assign hdr_after_tlast = build_hdr(PKT_DATA, has_time_q,
                                       (num_pkts_q != '0) && (pkt_cnt_d == num_pkts_q - CNT_W'(1)),
                                       seqno_d, lenb_q, sid_q);
    assign hdr_after_gap   = build_hdr(PKT_DATA, has_time_q,
                                       (num_pkts_q != '0) && (pkt_cnt_q == num_pkts_q - CNT_W'(1)),
                                       seqno_q, lenb_q, sid_q);

    // NOTE: one clocked process owns state and outputs, so every output is a flop
    // and o_tvalid can never see o_tready through combinational logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            o_tdata_q    <= '0;
            o_tlast_q    <= 1'b0;
            o_tvalid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pkt_cnt_q    <= '0;
            seqno_q      <= '0;
            stop_seen_q  <= 1'b0;
            num_pkts_q   <= '0;
            len_q        <= '0;
            lenb_q       <= '0;
            ramp_start_q <= '0;
            ramp_incr_q  <= '0;
            gap_q        <= '0;
            sid_q        <= '0;
            has_time_q   <= 1'b0;
            ts_q         <= '0;
            acc_q        <= '0;
            word_cnt_q   <= '0;
            gap_cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && stop) begin
                stop_seen_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_pkts_q   <= num_pkts;
                        len_q        <= len_eff;
                        lenb_q       <= len_bytes(32'(len_eff), has_time);
                        ramp_start_q <= ramp_start;
                        ramp_incr_q  <= ramp_incr;
                        gap_q        <= gap_cycles;
                        sid_q        <= sid;
                        has_time_q   <= has_time;
                        ts_q         <= timestamp;
                        acc_q        <= ramp_start;
                        pkt_cnt_q    <= '0;
                        seqno_q      <= '0;
                        stop_seen_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        o_tdata_q    <= build_hdr(PKT_DATA, has_time, num_pkts == CNT_W'(1),
                                                  '0, len_bytes(32'(len_eff), has_time), sid);
                        o_tlast_q    <= 1'b0;
                        o_tvalid_q   <= 1'b1;
                        state_q      <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    if (xfer) begin
                        if (has_time_q) begin
                            o_tdata_q <= ts_q;
                            state_q   <= ST_TIME;
                        end else begin
                            o_tdata_q  <= acc_q;
                            acc_q      <= acc_q + ramp_incr_q;
                            word_cnt_q <= '0;
                            o_tlast_q  <= (len_q == LEN_W'(1));
                            state_q    <= ST_PAYLOAD;
                        end
                    end
                end

                ST_TIME: begin
                    if (xfer) begin
                        o_tdata_q  <= acc_q;
                        acc_q      <= acc_q + ramp_incr_q;
                        word_cnt_q <= '0;
                        o_tlast_q  <= (len_q == LEN_W'(1));
                        state_q    <= ST_PAYLOAD;
                    end
                end

                ST_PAYLOAD: begin
                    if (xfer) begin
                        if (o_tlast_q) begin
                            pkt_cnt_q <= pkt_cnt_d;
                            seqno_q   <= seqno_d;
                            ts_q      <= ts_d;
                            acc_q     <= ramp_start_q;
                            o_tlast_q <= 1'b0;
                            if (gap_q != '0) begin
                                o_tvalid_q <= 1'b0;
                                gap_cnt_q  <= gap_q - 16'd1;
                                state_q    <= ST_GAP;
                            end else if (end_after_tlast) begin
                                o_tvalid_q  <= 1'b0;
                                o_tdata_q   <= '0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                stop_seen_q <= 1'b0;
                                state_q     <= ST_IDLE;
                            end else begin
                                o_tdata_q <= hdr_after_tlast;
                                state_q   <= ST_HDR;
                            end
                        end else begin
                            o_tdata_q  <= acc_q;
                            acc_q      <= acc_q + ramp_incr_q;
                            word_cnt_q <= word_d;
                            o_tlast_q  <= (word_d == len_q - LEN_W'(1));
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - 16'd1;
                    end else if (end_after_gap) begin
                        o_tdata_q   <= '0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        stop_seen_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        o_tdata_q  <= hdr_after_gap;
                        o_tvalid_q <= 1'b1;
                        state_q    <= ST_HDR;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_tvalid = o_tvalid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_cvita_ramp_pkt_gen.sv
// Scoreboard bench for cvita_ramp_pkt_gen: stimulus pushes expected stream words,
// a negedge monitor pops and compares every transfer and checks stall stability.
module tb_cvita_ramp_pkt_gen;

    localparam int LEN_W = 13;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] num_pkts;
    logic [LEN_W-1:0] payload_len;
    logic [63:0]      ramp_start;
    logic [63:0]      ramp_incr;
    logic [15:0]      gap_cycles;
    logic [31:0]      sid;
    logic             has_time;
    logic [63:0]      timestamp;
    logic [63:0]      o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pkt_cnt;

    always #5 clk = ~clk;

    cvita_ramp_pkt_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .num_pkts    (num_pkts),
        .payload_len (payload_len),
        .ramp_start  (ramp_start),
        .ramp_incr   (ramp_incr),
        .gap_cycles  (gap_cycles),
        .sid         (sid),
        .has_time    (has_time),
        .timestamp   (timestamp),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .busy        (busy),
        .done        (done),
        .pkt_cnt     (pkt_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   gaps[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected packet: header, optional timestamp, ramp payload with tlast on the final word
    task automatic push_pkt(input logic [11:0] seq, input bit eob, input bit ht,
                            input logic [63:0] ts, input int len, input logic [63:0] rs,
                            input logic [63:0] ri, input logic [31:0] s);
        exp_t        e;
        logic [63:0] acc;
        int          n;
        logic [15:0] lb;
        n      = (len == 0) ? 1 : len;
        lb     = 16'((1 + int'(ht) + n) * 8);
        e.data = {2'b00, ht, eob, seq, lb, s};
        e.last = 1'b0;
        exp_q.push_back(e);
        if (ht) begin
            e.data = ts;
            exp_q.push_back(e);
        end
        acc = rs;
        for (int k = 0; k < n; k++) begin
            e.data = acc;
            e.last = (k == n - 1);
            exp_q.push_back(e);
            acc = acc + ri;
        end
    endtask

    task automatic pulse_start(input bit with_stop);
        start = 1'b1;
        stop  = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_complete"}, 64'(ok), 64'd1);
        @(negedge clk);
        check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_ctl(input int np, input int len, input logic [63:0] rs,
                           input logic [63:0] ri, input int gap, input logic [31:0] s,
                           input bit ht, input logic [63:0] ts);
        num_pkts    = CNT_W'(np);
        payload_len = LEN_W'(len);
        ramp_start  = rs;
        ramp_incr   = ri;
        gap_cycles  = 16'(gap);
        sid         = s;
        has_time    = ht;
        timestamp   = ts;
    endtask

    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pop, stall hold checks, done pulses, inter-packet idle cycles
    initial begin
        bit          prev_stall = 1'b0;
        logic [63:0] prev_data  = '0;
        logic        prev_last  = 1'b0;
        bit          after_last = 1'b0;
        int          idle       = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                after_last = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(o_tvalid), 64'd1);
                    check("hold_data", o_tdata, prev_data);
                    check("hold_last", 64'(o_tlast), 64'(prev_last));
                end
                prev_stall = o_tvalid && !o_tready;
                prev_data  = o_tdata;
                prev_last  = o_tlast;
                if (done) done_cnt++;
                if (!busy) begin
                    after_last = 1'b0;
                end else if (o_tvalid) begin
                    if (after_last) begin
                        gaps.push_back(idle);
                        after_last = 1'b0;
                    end
                end else if (after_last) begin
                    idle++;
                end
                if (o_tvalid && o_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h expected no transfer", o_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", o_tdata, e.data);
                        check("word_last", 64'(o_tlast), 64'(e.last));
                    end
                    if (o_tlast) begin
                        after_last = 1'b1;
                        idle       = 0;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        set_ctl(0, 0, '0, '0, 0, '0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_tdata", o_tdata, 64'd0);
        check("rst_tlast", 64'(o_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single 16-word packet, no timestamp
        set_ctl(1, 16, 64'h0, 64'h100, 0, 32'hABCD_0001, 1'b0, '0);
        push_pkt(12'h000, 1'b1, 1'b0, '0, 16, 64'h0, 64'h100, 32'hABCD_0001);
        done_cnt = 0;
        pulse_start(1'b0);
        check("t1_hdr_latency", 64'(o_tvalid), 64'd1);
        wait_idle("t1", 200);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("t1_done_low", 64'(done), 64'd0);

        // 1b: ramp wraps past all-ones, back-to-back packets with zero gap
        set_ctl(2, 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 32'h0000_0B0B, 1'b0, '0);
        push_pkt(12'h000, 1'b0, 1'b0, '0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h0000_0B0B);
        push_pkt(12'h001, 1'b1, 1'b0, '0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h0000_0B0B);
        gaps.delete();
        done_cnt = 0;
        pulse_start(1'b0);
        wait_idle("t1b", 200);
        check("t1b_gap_count", 64'(gaps.size()), 64'd1);
        if (gaps.size() > 0) check("t1b_gap0", 64'(gaps[0]), 64'd0);
        check("t1b_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // 2: ten timestamped packets with 30-cycle gaps; controls changed mid-run are ignored
        set_ctl(10, 20, 64'h10, 64'h3, 30, 32'h00C0_FFEE, 1'b1, 64'h1000);
        for (int n = 0; n < 10; n++)
            push_pkt(12'(n), n == 9, 1'b1, 64'h1000 + 64'(20 * n), 20, 64'h10, 64'h3, 32'h00C0_FFEE);
        gaps.delete();
        done_cnt = 0;
        pulse_start(1'b0);
        set_ctl(1, 5, 64'hDEAD_BEEF, 64'h7, 2, 32'h1234_5678, 1'b0, 64'h9999);
        wait_idle("t2", 2000);
        check("t2_gap_count", 64'(gaps.size()), 64'd9);
        foreach (gaps[i]) check("t2_gap", 64'(gaps[i]), 64'd30);
        check("t2_pkt_cnt", 64'(pkt_cnt), 64'd10);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);

        // 3: case 1 under random backpressure
        set_ctl(1, 16, 64'h0, 64'h100, 0, 32'hABCD_0001, 1'b0, '0);
        push_pkt(12'h000, 1'b1, 1'b0, '0, 16, 64'h0, 64'h100, 32'hABCD_0001);
        done_cnt   = 0;
        rand_ready = 1'b1;
        pulse_start(1'b0);
        wait_idle("t3", 500);
        rand_ready = 1'b0;
        check("t3_done_cnt", 64'(done_cnt), 64'd1);
        check("t3_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // 4: continuous run past the seqno wrap, stop while packet 4100 is in flight
        set_ctl(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 32'h0004_0004, 1'b0, '0);
        for (int n = 0; n < 4101; n++)
            push_pkt(12'(n % 4096), 1'b0, 1'b0, '0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h0004_0004);
        done_cnt = 0;
        pulse_start(1'b0);
        found = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (pkt_cnt == CNT_W'(4100)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t4_reached_4100", 64'(found), 64'd1);
        check("t4_mid_packet", 64'(o_tlast), 64'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("t4", 100);
        check("t4_done_cnt", 64'(done_cnt), 64'd1);
        check("t4_pkt_cnt", 64'(pkt_cnt), 64'd4101);
        check("t4_busy", 64'(busy), 64'd0);

        // 5: reset while payload word 5 of 1024 is presented, then a fresh run
        set_ctl(1, 1024, 64'h1000, 64'h1, 0, 32'h0005_0005, 1'b0, '0);
        push_pkt(12'h000, 1'b1, 1'b0, '0, 1024, 64'h1000, 64'h1, 32'h0005_0005);
        pulse_start(1'b0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (o_tvalid && o_tdata == 64'h1005) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_reached_word5", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_tvalid", 64'(o_tvalid), 64'd0);
        check("t5_rst_tdata", o_tdata, 64'd0);
        check("t5_rst_tlast", 64'(o_tlast), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_ctl(1, 4, 64'h1000, 64'h1, 0, 32'h0005_0005, 1'b0, '0);
        push_pkt(12'h000, 1'b1, 1'b0, '0, 4, 64'h1000, 64'h1, 32'h0005_0005);
        done_cnt = 0;
        pulse_start(1'b0);
        wait_idle("t5", 100);
        check("t5_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("t5_done_cnt", 64'(done_cnt), 64'd1);

        // 6: zero length means one word; stop with start is dropped; start while busy ignored
        set_ctl(3, 0, 64'h55, 64'h2, 2, 32'h0006_0006, 1'b0, '0);
        for (int n = 0; n < 3; n++)
            push_pkt(12'(n), n == 2, 1'b0, '0, 1, 64'h55, 64'h2, 32'h0006_0006);
        done_cnt = 0;
        pulse_start(1'b1);
        @(negedge clk);
        set_ctl(1, 9, 64'hAAAA, 64'h1, 0, 32'hDEAD_0000, 1'b1, 64'h77);
        pulse_start(1'b0);
        wait_idle("t6", 200);
        check("t6_pkt_cnt", 64'(pkt_cnt), 64'd3);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
